// File: rtl/lane_serializer.sv
// lane_serializer: valid/ready word to multi-lane serial beats, optional even-parity beat, one-word holding buffer
// Ports: clk, rst_n (async active-low); parallel_in/valid/ready word input handshake;
//        serial_out (LANES wide), enable, start, last, busy registered beat outputs.
module lane_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 1,
  parameter int LSB_FIRST  = 0,
  parameter int PARITY_EN  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] parallel_in,
  input  logic                  valid,
  output logic                  ready,
  output logic [LANES-1:0]      serial_out,
  output logic                  enable,
  output logic                  start,
  output logic                  last,
  output logic                  busy
);
  localparam int WORD_BEATS = DATA_WIDTH / LANES;
  localparam int BEATS = WORD_BEATS + PARITY_EN;
  localparam int CW = $clog2(BEATS) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [CW-1:0] PAR_BEAT = CW'(WORD_BEATS);
  logic [DATA_WIDTH-1:0] sh_q, sh_d, buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic act_q, act_d, par_q, par_d, buf_valid_q, buf_valid_d;
  logic [LANES-1:0] serial_q, serial_d;
  logic enable_q, start_q, last_q, busy_q;
  logic accept, on_last;
  assign ready = !buf_valid_q;
  assign accept = valid && ready;
  assign on_last = act_q && cnt_q == LAST_BEAT;
  always_comb begin
    sh_d = sh_q;
    buf_d = buf_q;
    cnt_d = cnt_q;
    act_d = act_q;
    par_d = par_q;
    buf_valid_d = buf_valid_q;
    if (!act_q || on_last) begin
      if (buf_valid_q) begin
        sh_d = buf_q;
        par_d = ^buf_q;
        cnt_d = '0;
        act_d = 1'b1;
        buf_valid_d = 1'b0;
      end else if (accept) begin
        sh_d = parallel_in;
        par_d = ^parallel_in;
        cnt_d = '0;
        act_d = 1'b1;
      end else begin
        act_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
      sh_d = LSB_FIRST != 0 ? sh_q >> LANES : sh_q << LANES;
      if (accept) begin
        buf_d = parallel_in;
        buf_valid_d = 1'b1;
      end
    end
  end
  // Outputs are registered from next state so each beat appears the cycle after it is scheduled.
  assign serial_d = !act_d ? '0 : cnt_d == PAR_BEAT ? {LANES{par_d}} :
                    LSB_FIRST != 0 ? sh_d[LANES-1:0] : sh_d[DATA_WIDTH-1 -: LANES];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
      buf_q <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
      par_q <= 1'b0;
      buf_valid_q <= 1'b0;
      serial_q <= '0;
      enable_q <= 1'b0;
      start_q <= 1'b0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      sh_q <= sh_d;
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      act_q <= act_d;
      par_q <= par_d;
      buf_valid_q <= buf_valid_d;
      serial_q <= serial_d;
      enable_q <= act_d;
      start_q <= act_d && cnt_d == '0;
      last_q <= act_d && cnt_d == LAST_BEAT;
      busy_q <= act_d || buf_valid_d;
    end
  end
  assign serial_out = serial_q;
  assign enable = enable_q;
  assign start = start_q;
  assign last = last_q;
  assign busy = busy_q;
endmodule
